line_burst_adapter: RTL and testbench

LINE_BURST_ADAPTER -- requirements
Module: line_burst_adapter

---
 rtl/line_burst_adapter_pkg.sv | 39 +++
 rtl/line_burst_adapter.sv | 127 ++++++++++++
 tb/tb_line_burst_adapter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/line_burst_adapter_pkg.sv
// ---------------------------------------------------------------------------
// line_burst_adapter_pkg
//   Shared cache package: cache-side control types, the line/beat geometry
//   constants and the burst-adapter state encoding.
//   Contents:
//     LINE_W, ADDR_W, BEATS_DEF, BEAT_W_DEF  - line and beat geometry
//     cache_op_t                             - cache-to-memory operation kind
//     burst_state_t                          - burst adapter FSM states
//     line_align()                           - clears the line-offset bits
// ---------------------------------------------------------------------------
package line_burst_adapter_pkg;

  localparam int LINE_W     = 256;
  localparam int ADDR_W     = 32;
  localparam int BEATS_DEF  = 4;
  localparam int BEAT_W_DEF = 64;

  // Byte offset within a 32-byte line.
  localparam logic [ADDR_W-1:0] LINE_OFFSET_MASK = 32'h0000_001F;

  // Cache control types shared with the cache controller.
  typedef enum logic [1:0] {
    CACHE_OP_NONE,
    CACHE_OP_FILL,
    CACHE_OP_WRITEBACK
  } cache_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_DONE
  } burst_state_t;

  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
    return addr & ~LINE_OFFSET_MASK;
  endfunction

endpackage

// File: rtl/line_burst_adapter.sv
// ---------------------------------------------------------------------------
// line_burst_adapter
//   Converts whole-line cache requests into BEATS-beat memory bursts.
//   A write-back streams the latched line out beat 0 (LSB) first; a line fill
//   assembles incoming beats into line_o. resp_o pulses once per finished line.
//   Ports:
//     clk, rst            - clock, asynchronous active-high reset
//     line_i / line_o     - line to write back / assembled fill line
//     address_i, read_i, write_i, resp_o - cache-side request handshake
//     burst_i / burst_o   - beat from / to physical memory
//     address_o, read_o, write_o, resp_i - memory-side burst handshake
// ---------------------------------------------------------------------------
module line_burst_adapter
  import line_burst_adapter_pkg::*;
#(
  parameter int BEATS  = BEATS_DEF,
  parameter int BEAT_W = BEAT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LINE_W-1:0] line_i,
  output logic [LINE_W-1:0] line_o,
  input  logic [ADDR_W-1:0] address_i,
  input  logic              read_i,
  input  logic              write_i,
  output logic              resp_o,
  input  logic [BEAT_W-1:0] burst_i,
  output logic [BEAT_W-1:0] burst_o,
  output logic [ADDR_W-1:0] address_o,
  output logic              read_o,
  output logic              write_o,
  input  logic              resp_i
);

  localparam int              CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  if (BEATS * BEAT_W != LINE_W) begin : g_bad_geometry
    $error("line_burst_adapter: BEATS*BEAT_W must equal LINE_W");
  end

  burst_state_t      state_q, state_d;
  logic [CNT_W-1:0]  count_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wline_q;
  logic [LINE_W-1:0] rline_q;
  logic              last_beat;

  assign last_beat = resp_i && (count_q == LAST_BEAT);

  // Next-state logic. resp_i only matters inside a burst, so strobes seen
  // in IDLE or DONE never advance anything.
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (write_i)     state_d = ST_WRITE;
        else if (read_i) state_d = ST_READ;
      end
      ST_READ,
      ST_WRITE: if (last_beat) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs decode from registered state only, so a reset clears them in
  // the same cycle it is applied.
  always_comb begin
    read_o  = 1'b0;
    write_o = 1'b0;
    resp_o  = 1'b0;
    burst_o = '0;
    unique case (state_q)
      ST_READ:  read_o = 1'b1;
      ST_WRITE: begin
        write_o = 1'b1;
        burst_o = wline_q[int'(count_q)*BEAT_W +: BEAT_W];
      end
      ST_DONE:  resp_o = 1'b1;
      default:  ;
    endcase
  end

  assign address_o = line_align(addr_q);
  assign line_o    = rline_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      addr_q  <= '0;
      rline_q <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        ST_IDLE: begin
          count_q <= '0;
          if (write_i || read_i) addr_q <= address_i;
        end
        ST_READ: begin
          if (resp_i) begin
            // Beats land in place; line_o keeps the previous line's upper
            // beats until they are overwritten by this fill.
            rline_q[int'(count_q)*BEAT_W +: BEAT_W] <= burst_i;
            count_q <= last_beat ? '0 : count_q + CNT_W'(1);
          end
        end
        ST_WRITE: begin
          if (resp_i) count_q <= last_beat ? '0 : count_q + CNT_W'(1);
        end
        default: count_q <= '0;
      endcase
    end
  end

  // NOTE: the write-back buffer is not reset; it is always loaded before
  // WRITE is entered and burst_o is forced to 0 outside WRITE.
  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && write_i) wline_q <= line_i;
  end

endmodule

// File: tb/tb_line_burst_adapter.sv
// ---------------------------------------------------------------------------
// tb_line_burst_adapter
//   Self-checking bench for line_burst_adapter: a transaction-level model
//   tracks the expected outputs every cycle, and directed tests pin literal
//   results (addresses, assembled lines, write beat order, reset behaviour).
// ---------------------------------------------------------------------------
module tb_line_burst_adapter;

  localparam int BW = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [255:0] line_i = '0;
  logic [255:0] line_o;
  logic [31:0]  address_i = '0;
  logic         read_i = 1'b0;
  logic         write_i = 1'b0;
  logic         resp_o;
  logic [63:0]  burst_i = '0;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i = 1'b0;

  int total = 0;
  int bad   = 0;

  logic [63:0] got_beats[$];

  line_burst_adapter #(.BEATS(4), .BEAT_W(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // Tracks which line transfer is in flight, how many beats have moved,
  // and whether the completion pulse is owed this cycle.
  typedef enum {M_NONE, M_RD, M_WR} dir_t;
  dir_t         m_dir   = M_NONE;
  int           m_beats = 0;
  bit           m_resp  = 1'b0;
  logic [31:0]  m_addr  = '0;
  logic [255:0] m_wline = '0;
  logic [255:0] m_line  = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_dir = M_NONE; m_beats = 0; m_resp = 1'b0; m_addr = '0; m_line = '0;
    end else if (m_resp) begin
      m_resp = 1'b0;
    end else if (m_dir == M_NONE) begin
      if (write_i) begin
        m_dir = M_WR; m_addr = address_i; m_wline = line_i; m_beats = 0;
      end else if (read_i) begin
        m_dir = M_RD; m_addr = address_i; m_beats = 0;
      end
    end else if (resp_i) begin
      if (m_dir == M_RD) m_line[m_beats*BW +: BW] = burst_i;
      m_beats++;
      if (m_beats == 4) begin
        m_dir  = M_NONE;
        m_resp = 1'b1;
      end
    end
  end

  // Outputs are sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      check("read_o",    256'(read_o),    256'(m_dir == M_RD));
      check("write_o",   256'(write_o),   256'(m_dir == M_WR));
      check("resp_o",    256'(resp_o),    256'(m_resp));
      check("address_o", 256'(address_o), 256'({m_addr[31:5], 5'b0}));
      check("burst_o",   256'(burst_o),
            (m_dir == M_WR) ? 256'(m_wline[m_beats*BW +: BW]) : 256'(0));
      check("line_o",    line_o,          m_line);
    end
  end

  // One line transfer: request, resp_i pattern (bit i used in cycle i),
  // then the completion pulse. Write beats seen on burst_o are collected.
  task automatic burst(input bit wr, input bit rd, input logic [31:0] addr,
                       input logic [255:0] data, input logic [15:0] pat, input int len);
    int k;
    k = 0;
    got_beats.delete();
    @(negedge clk);
    address_i = addr;
    line_i    = data;
    write_i   = wr;
    read_i    = rd;
    resp_i    = 1'b0;
    @(negedge clk);
    for (int i = 0; i < len; i++) begin
      resp_i  = pat[i];
      burst_i = pat[i] ? data[k*BW +: BW] : 64'hDEAD_BEEF_0BAD_F00D;
      if (pat[i]) begin
        if (wr) got_beats.push_back(burst_o);
        check("lit_resp_early", 256'(resp_o), 256'(0));
        k++;
      end
      @(negedge clk);
    end
    resp_i = 1'b0;
    check("lit_resp_pulse", 256'(resp_o), 256'(1));
    read_i  = 1'b0;
    write_i = 1'b0;
    @(negedge clk);
    check("lit_resp_once", 256'(resp_o), 256'(0));
  endtask

  localparam logic [255:0] RD_LINE = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                      64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
  localparam logic [255:0] WR_LINE = {64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
                                      64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD};
  localparam logic [255:0] ST_LINE = {64'h0D0D_0D0D_0D0D_0D0D, 64'h0C0C_0C0C_0C0C_0C0C,
                                      64'h0B0B_0B0B_0B0B_0B0B, 64'h0A0A_0A0A_0A0A_0A0A};
  localparam logic [255:0] R2_LINE = {64'h8888_0000_0000_0004, 64'h8888_0000_0000_0003,
                                      64'h8888_0000_0000_0002, 64'h8888_0000_0000_0001};

  initial begin
    // Reset state.
    #12;
    check("rst_line_o",    line_o,               256'(0));
    check("rst_address_o", 256'(address_o),      256'(0));
    check("rst_ctrl",      256'({read_o, write_o, resp_o}), 256'(0));
    check("rst_burst_o",   256'(burst_o),        256'(0));
    @(negedge clk);
    rst = 1'b0;

    // Plain line fill.
    burst(1'b0, 1'b1, 32'h1234_5678, RD_LINE, 16'h000F, 4);
    check("lit_rd_addr", 256'(address_o), 256'(32'h1234_5660));
    check("lit_rd_line", line_o, RD_LINE);

    // Spurious memory strobes while idle.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      resp_i  = 1'b1;
      burst_i = 64'hFFFF_0000_FFFF_0000;
    end
    @(negedge clk);
    resp_i = 1'b0;
    check("lit_idle_line", line_o, RD_LINE);
    check("lit_idle_ctrl", 256'({read_o, write_o, resp_o}), 256'(0));

    // Write-back: beats leave LSB first.
    burst(1'b1, 1'b0, 32'hABCD_EF1F, WR_LINE, 16'h000F, 4);
    check("lit_wr_nbeats", 256'(got_beats.size()), 256'(4));
    if (got_beats.size() == 4) begin
      check("lit_wr_beat0", 256'(got_beats[0]), 256'(64'hDDDD_DDDD_DDDD_DDDD));
      check("lit_wr_beat1", 256'(got_beats[1]), 256'(64'hCCCC_CCCC_CCCC_CCCC));
      check("lit_wr_beat2", 256'(got_beats[2]), 256'(64'hBBBB_BBBB_BBBB_BBBB));
      check("lit_wr_beat3", 256'(got_beats[3]), 256'(64'hAAAA_AAAA_AAAA_AAAA));
    end
    check("lit_wr_addr", 256'(address_o), 256'(32'hABCD_EF00));
    check("lit_wr_burst_idle", 256'(burst_o), 256'(0));

    // Stalled fill: pattern 1,0,0,1,1,0,1.
    burst(1'b0, 1'b1, 32'h0000_0040, ST_LINE, 16'h0059, 7);
    check("lit_stall_line", line_o, ST_LINE);

    // Both requests at once: write wins, read_o never rises.
    burst(1'b1, 1'b1, 32'h0000_1000, WR_LINE, 16'h000F, 4);
    check("lit_both_beat0", 256'(got_beats.size() > 0 ? got_beats[0] : 64'h0),
          256'(64'hDDDD_DDDD_DDDD_DDDD));
    check("lit_both_line", line_o, ST_LINE);

    // Reset after two read beats.
    @(negedge clk);
    address_i = 32'h0000_0FE4;
    read_i    = 1'b1;
    resp_i    = 1'b0;
    @(negedge clk);
    resp_i  = 1'b1;
    burst_i = 64'h5555_5555_5555_5555;
    @(negedge clk);
    burst_i = 64'h6666_6666_6666_6666;
    @(negedge clk);
    resp_i = 1'b0;
    check("lit_mid_read_o", 256'(read_o), 256'(1));
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("lit_mrst_ctrl",  256'({read_o, write_o, resp_o}), 256'(0));
    check("lit_mrst_addr",  256'(address_o), 256'(0));
    check("lit_mrst_burst", 256'(burst_o),   256'(0));
    check("lit_mrst_line",  line_o,          256'(0));
    read_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("lit_mrst_noresp", 256'(resp_o), 256'(0));

    // A fresh fill after the abandoned one.
    burst(1'b0, 1'b1, 32'h8000_003C, R2_LINE, 16'h000F, 4);
    check("lit_r2_line", line_o, R2_LINE);
    check("lit_r2_addr", 256'(address_o), 256'(32'h8000_0020));

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog expired");
  end

endmodule
